// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// SPI mode-0 master (CPOL=0, CPHA=0). Each transfer shifts one byte out on
// mosi and captures one byte from miso. A local controller starts a transfer
// with start/tx_data and sees busy while it runs, then a one-cycle done pulse
// with rx_data updated.
//
// Parameters
//   CLK_DIV   sck half-period in clk cycles, legal range 1..255 (default 2)
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   transfer request, accepted in IDLE or during the done cycle
//   tx_data   in   [7:0] byte to send, latched on the accepting edge
//   rx_data   out  [7:0] last received byte, updated when done asserts
//   busy      out  high from the cycle after acceptance until done
//   done      out  one-cycle completion pulse
//   sck       out  SPI clock, idles low
//   cs        out  chip select, active low, idles high
//   mosi      out  serial data out
//   miso      in   serial data in (slave changes it on falling sck)
//
// Build option
//   SPI_MASTER_LSB_FIRST_EN  when defined, bits go out and come in LSB first;
//                            otherwise MSB first. Timing is the same either way.
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  // Last value of the divider count in each timed state; every timed state
  // therefore lasts exactly CLK_DIV cycles.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] div_cnt;
  logic [7:0] div_cnt_next;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_next;
  logic [7:0] tx_shift;
  logic [7:0] tx_shift_next;
  logic [7:0] rx_shift;
  logic [7:0] rx_shift_next;
  logic [7:0] rx_data_next;
  logic       sck_next;
  logic       cs_next;
  logic       mosi_next;
  logic       busy_next;
  logic       done_next;

  logic       div_wrap;
  logic [7:0] tx_advanced;
  logic [7:0] rx_captured;

  assign div_wrap = (div_cnt == DIV_LAST);

  // Shift direction depends on bit order: the bit on the wire is always the
  // end of tx_shift that leaves first, and miso enters at the opposite end so
  // that after 8 samples the first received bit sits where it belongs.
  assign tx_advanced = LSB_FIRST ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
  assign rx_captured = LSB_FIRST ? {miso, rx_shift[7:1]} : {rx_shift[6:0], miso};

  // Next-state and next-output logic. All pin outputs are registered from
  // their next values so sck/cs/mosi never glitch on state decode.
  always_comb begin
    state_next    = state;
    div_cnt_next  = div_cnt;
    bit_cnt_next  = bit_cnt;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;

    case (state)
      IDLE: begin
        if (start) begin
          state_next    = SETUP;
          div_cnt_next  = '0;
          bit_cnt_next  = '0;
          tx_shift_next = tx_data;
        end
      end

      SETUP: begin
        if (div_wrap) begin
          // This edge raises sck, so it is also the first miso sample.
          state_next    = HIGH;
          div_cnt_next  = '0;
          rx_shift_next = rx_captured;
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end

      HIGH: begin
        if (div_wrap) begin
          div_cnt_next = '0;
          if (bit_cnt == 3'd7) begin
            state_next = HOLD;
          end else begin
            state_next    = LOW;
            bit_cnt_next  = bit_cnt + 3'd1;
            tx_shift_next = tx_advanced;
          end
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end

      LOW: begin
        if (div_wrap) begin
          state_next    = HIGH;
          div_cnt_next  = '0;
          rx_shift_next = rx_captured;
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end

      HOLD: begin
        if (div_wrap) begin
          state_next   = DONE;
          div_cnt_next = '0;
          rx_data_next = rx_shift;
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end

      DONE: begin
        // A start here chains straight into the next transfer, leaving cs
        // high for just this one cycle.
        if (start) begin
          state_next    = SETUP;
          div_cnt_next  = '0;
          bit_cnt_next  = '0;
          tx_shift_next = tx_data;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        div_cnt_next = '0;
        bit_cnt_next = '0;
      end
    endcase

    busy_next = (state_next == SETUP) || (state_next == HIGH) ||
                (state_next == LOW)   || (state_next == HOLD);
    cs_next   = ~busy_next;
    sck_next  = (state_next == HIGH);
    done_next = (state_next == DONE);
    // mosi only carries data while bits are on the wire; it drops to 0 in
    // HOLD, DONE and IDLE.
    if ((state_next == SETUP) || (state_next == HIGH) || (state_next == LOW)) begin
      mosi_next = LSB_FIRST ? tx_shift_next[0] : tx_shift_next[7];
    end else begin
      mosi_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      sck      <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      div_cnt  <= div_cnt_next;
      bit_cnt  <= bit_cnt_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      rx_data  <= rx_data_next;
      sck      <= sck_next;
      cs       <= cs_next;
      mosi     <= mosi_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Self-checking bench for spi_master. A CLK_DIV=2 instance is exercised in
// loopback and against a small behavioural SPI slave; a CLK_DIV=1 instance
// runs in loopback. Expected received bytes go into a scoreboard queue when a
// transfer is launched and are compared when done pulses.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int CLK_DIV    = 2;
  localparam int DONE_CYCLE = 1 + 17 * CLK_DIV;
  localparam int BUDGET     = 40 * CLK_DIV + 20;

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sck;
  logic       cs;
  logic       mosi;
  logic       miso;

  logic       start_fast;
  logic [7:0] tx_fast;
  logic [7:0] rx_fast;
  logic       busy_fast;
  logic       done_fast;
  logic       sck_fast;
  logic       cs_fast;
  logic       mosi_fast;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sck     (sck),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso)
  );

  spi_master #(.CLK_DIV(1)) dut_fast (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_fast),
    .tx_data (tx_fast),
    .rx_data (rx_fast),
    .busy    (busy_fast),
    .done    (done_fast),
    .sck     (sck_fast),
    .cs      (cs_fast),
    .mosi    (mosi_fast),
    .miso    (mosi_fast)
  );

  // Behavioural mode-0 slave: loads its reply when cs falls, captures mosi on
  // rising sck and moves to its next bit on falling sck.
  logic       loop_mode;
  logic [7:0] slave_tx;
  logic [7:0] slave_shift = 8'h00;
  logic [7:0] slave_rx    = 8'h00;
  logic       slave_miso;

  always @(negedge cs) slave_shift = slave_tx;
  always @(posedge sck) slave_rx = LSB_FIRST ? {mosi, slave_rx[7:1]} : {slave_rx[6:0], mosi};
  always @(negedge sck) slave_shift = LSB_FIRST ? (slave_shift >> 1) : (slave_shift << 1);
  assign slave_miso = LSB_FIRST ? slave_shift[0] : slave_shift[7];
  assign miso       = loop_mode ? mosi : slave_miso;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave_byte;
    bit         loopback;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic txBit(input logic [7:0] b, input int k);
    return LSB_FIRST ? b[k] : b[7 - k];
  endfunction

  // Called one cycle after the accepting edge (cycle 1). Follows the transfer
  // until done, checking bit order, sck count, cs width and done timing, then
  // pops the scoreboard. Returns while done is high.
  task automatic watchTransfer(input logic [7:0] tx, input int poke_cycle, input string name);
    int         cycle;
    int         rises;
    int         cs_low;
    logic       prev_sck;
    logic [7:0] expv;
    cycle    = 1;
    rises    = 0;
    cs_low   = 0;
    prev_sck = 1'b0;
    checkOutput({name, " cycle1 cs/busy/mosi"}, {29'd0, cs, busy, mosi}, {29'd0, 1'b0, 1'b1, txBit(tx, 0)});
    while (done !== 1'b1 && cycle < BUDGET) begin
      if (cs === 1'b0) cs_low++;
      if (cycle == poke_cycle) begin
        start   = 1'b1;
        tx_data = 8'h33;
      end else begin
        start   = 1'b0;
        tx_data = ~tx;
      end
      tick();
      cycle++;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        if (rises < 8) checkOutput({name, " mosi at rise"}, {31'd0, mosi}, {31'd0, txBit(tx, rises)});
        rises++;
      end
      prev_sck = sck;
    end
    start = 1'b0;
    checkOutput({name, " done seen"}, {31'd0, done}, 32'd1);
    checkOutput({name, " done cycle"}, cycle, DONE_CYCLE);
    checkOutput({name, " sck rises"}, rises, 8);
    checkOutput({name, " cs low cycles"}, cs_low, DONE_CYCLE - 1);
    checkOutput({name, " done cs/busy"}, {30'd0, cs, busy}, {30'd0, 2'b10});
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s scoreboard: got rx %0h, expected queue entry none", name, rx_data);
    end else begin
      expv = exp_q.pop_front();
      checkOutput({name, " rx_data"}, {24'd0, rx_data}, {24'd0, expv});
    end
  endtask

  task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] exp_rx, input int poke_cycle, input string name);
    tx_data = tx;
    start   = 1'b1;
    exp_q.push_back(exp_rx);
    tick();
    watchTransfer(tx, poke_cycle, name);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         rises;
    int         cycles;
    logic       prev;

    vecs[0] = '{8'hAA, 8'h00, 1'b1, 8'hAA};
    vecs[1] = '{8'hA5, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{8'h00, 8'h3C, 1'b0, 8'h3C};
    vecs[3] = '{8'hFF, 8'h3C, 1'b0, 8'h3C};
    vecs[4] = '{8'h55, 8'h3C, 1'b0, 8'h3C};
    vecs[5] = '{8'h81, 8'hC3, 1'b0, 8'hC3};
    vecs[6] = '{8'h6E, 8'h00, 1'b1, 8'h6E};

    rst_n      = 1'b0;
    start      = 1'b0;
    tx_data    = 8'h00;
    start_fast = 1'b0;
    tx_fast    = 8'h00;
    loop_mode  = 1'b1;
    slave_tx   = 8'h00;
    tick();

    // Reset held with start toggling: outputs stay at reset values.
    for (int i = 0; i < 10; i++) begin
      start   = i[0];
      tx_data = 8'($urandom);
      tick();
      checkOutput($sformatf("reset hold %0d", i), {19'd0, cs, sck, mosi, busy, done, rx_data},
                  {19'd0, 5'b10000, 8'h00});
    end
    checkOutput("reset hold fast", {19'd0, cs_fast, sck_fast, mosi_fast, busy_fast, done_fast, rx_fast},
                {19'd0, 5'b10000, 8'h00});
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    checkOutput("idle after reset", {27'd0, cs, sck, mosi, busy, done}, {27'd0, 5'b10000});

    // Table-driven transfers in loopback and against the slave model.
    for (int i = 0; i < 7; i++) begin
      loop_mode = vecs[i].loopback;
      slave_tx  = vecs[i].slave_byte;
      applyStimulus(vecs[i].tx, vecs[i].exp_rx, -1, $sformatf("vec%0d", i));
      if (!vecs[i].loopback) begin
        checkOutput($sformatf("vec%0d slave data_out", i), {24'd0, slave_rx}, {24'd0, vecs[i].tx});
      end
      tick();
      tick();
      checkOutput($sformatf("vec%0d idle", i), {27'd0, cs, sck, mosi, busy, done}, {27'd0, 5'b10000});
    end

    // start during busy is ignored; start held in the done cycle chains.
    loop_mode = 1'b1;
    applyStimulus(8'h0F, 8'h0F, 10, "busy-ignore");
    tx_data = 8'h77;
    start   = 1'b1;
    exp_q.push_back(8'h77);
    tick();
    watchTransfer(8'h77, -1, "back-to-back");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("no queued start %0d", i), {23'd0, cs, busy, done, rx_data},
                  {23'd0, 3'b100, 8'h77});
    end

    // Reset after the 4th rising sck aborts cleanly.
    tx_data = 8'h96;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    rises  = 0;
    cycles = 0;
    prev   = 1'b0;
    while (rises < 4 && cycles < BUDGET) begin
      tick();
      cycles++;
      if (sck === 1'b1 && prev === 1'b0) rises++;
      prev = sck;
    end
    checkOutput("reset-mid reached 4th rise", rises, 4);
    rst_n = 1'b0;
    tick();
    checkOutput("reset-mid outputs", {19'd0, cs, sck, mosi, busy, done, rx_data}, {19'd0, 5'b10000, 8'h00});
    tick();
    checkOutput("reset-mid held", {19'd0, cs, sck, mosi, busy, done, rx_data}, {19'd0, 5'b10000, 8'h00});
    rst_n = 1'b1;
    tick();
    checkOutput("reset-mid released", {19'd0, cs, sck, mosi, busy, done, rx_data}, {19'd0, 5'b10000, 8'h00});
    applyStimulus(8'hCC, 8'hCC, -1, "after-reset");
    tick();

    // CLK_DIV=1 instance in loopback.
    tx_fast    = 8'h11;
    start_fast = 1'b1;
    tick();
    start_fast = 1'b0;
    tx_fast    = 8'hEE;
    cycles     = 1;
    checkOutput("fast first mosi", {31'd0, mosi_fast}, {31'd0, txBit(8'h11, 0)});
    while (done_fast !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    checkOutput("fast done cycle", cycles, 18);
    checkOutput("fast rx_data", {24'd0, rx_fast}, {24'd0, 8'h11});

    checkOutput("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 (CPOL=0, CPHA=0) master. It is the initiator counterpart to our `slave` block. It generates `sck`, `cs` and `mosi` from the system clock, and shifts one byte out while capturing one byte from `miso` per transaction. A simple start/busy/done handshake lets a local controller or register block launch transfers. The block is used both to drive off-chip SPI peripherals and as the stimulus/loopback partner for the slave in system-level benches.

## Interface
- `CLK_DIV`, default 2: `sck` half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  transfer request; accepted only when the block is idle (IDLE state) or during the `done` cycle.
- `tx_data`  in  8  byte to send; latched on the accepting edge.
- `rx_data`  out  8  last received byte; updated on the edge `done` asserts; holds until the next completion.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `sck`  out  1  SPI clock; idles low.
- `cs`  out  1  chip select, active low; idles high.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; the slave changes it on falling `sck`.

## Operation
- Reset values: `sck`=0, `cs`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=8'h00. FSM→IDLE, divider counter=0, bit counter=0.
- Internal state: 8-bit TX shift register, 8-bit RX shift register, 3-bit bit counter, 8-bit divider counter.
- States:
  - IDLE: `start`=1 → SETUP. Latch `tx_data`, drive `cs`=0, `mosi`=bit 7, set `busy`=1.
  - SETUP: wait `CLK_DIV` cycles with `sck`=0 → HIGH.
  - HIGH: `sck`=1. `miso` is sampled into the RX shift register on the edge that raises `sck`. After `CLK_DIV` cycles → LOW.
  - LOW: `sck`=0.
    - If bits remain: `mosi` advances to the next bit on the falling edge, wait `CLK_DIV` cycles → HIGH.
    - After the 8th falling edge: `mosi`=0 → HOLD.
  - HOLD: wait `CLK_DIV` cycles with `cs` still low → DONE.
  - DONE: one cycle. `cs`=1, `done`=1, `busy`=0, `rx_data` updated.
    - `start`=1 here → SETUP (back-to-back transfer).
    - Otherwise → IDLE.
- MSB first by default; exactly 8 `sck` rising edges per transfer.
- `start` while `busy`=1 is ignored and not queued. `tx_data` changes after acceptance have no effect.
- Reset asserted mid-transfer: all outputs take their reset values on the next edge. There is no partial `done` and `rx_data` is cleared.

## Timing
- Cycle 0 = edge where `start` is accepted. Cycle 1: `cs`=0, `busy`=1, `mosi`=tx[7].
- Rising `sck` for bit k (k=0..7): cycle 1+CLK_DIV+2k·CLK_DIV.
- Falling `sck` for bit k: cycle 1+2CLK_DIV+2k·CLK_DIV.
- `done`=1, `cs`=1, `busy`=0 at cycle 1+17·CLK_DIV. With CLK_DIV=2 this is cycle 35, and `cs` is low for 34 cycles.
- `mosi` setup to rising `sck` is CLK_DIV cycles; hold after rising `sck` is CLK_DIV cycles.
- Minimum `cs` high time between back-to-back transfers: 1 cycle.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - Defined: shift order is LSB first. `mosi`=tx[0] at cycle 1, and the first sampled `miso` bit lands in rx_data[0].
  - Undefined: MSB first, as described above.
  - Timing is identical in both cases.

## Test plan
- Reset: hold `rst_n`=0 for 10 cycles, toggling `start` → `cs`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=8'h00 throughout.
- Loopback (`miso` tied to `mosi`), CLK_DIV=2, send 8'hAA → `done` at cycle 35, `rx_data`=8'hAA, exactly 8 `sck` rising edges, `cs` low 34 cycles.
- Connect to the `slave` block returning 8'h3C, send 8'hA5 → master `rx_data`=8'h3C and slave `data_out`=8'hA5. Repeat for 8'h00, 8'hFF, 8'h55.
- Busy and back-to-back: pulse `start` with 8'h33 at cycle 10 of an ongoing 8'h0F transfer → ignored. Then hold `start` high with 8'h77 during `done` → `cs` high exactly 1 cycle, second transfer returns 8'h77 in loopback.
- Reset mid-transfer: assert `rst_n`=0 after the 4th rising `sck` → next edge all outputs at reset values, no `done`. A fresh 8'hCC transfer afterwards completes correctly.
- CLK_DIV=1 with `SPI_MASTER_LSB_FIRST_EN` defined, loopback 8'h11 → `done` at cycle 18, `rx_data`=8'h11, first `mosi` bit = 1 (tx[0]).
